// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register with redirect/stall/advance
// priority and a saturating stall counter.
module instruction_fetch_stage #(
  parameter int unsigned INSTR_WIDTH          = 16,
  parameter int unsigned INSTR_MEM_ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] instr_mem_addr,
  input  logic [INSTR_WIDTH-1:0]          instr_mem_data,
  input  logic                            pipeline_stall_n,
  input  logic                            branch_taken,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] branch_target,
  output logic [INSTR_WIDTH-1:0]          id_instr,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] id_pc,
  output logic                            id_valid,
  output logic [2:0]                      decoding_op_src1,
  output logic [2:0]                      decoding_op_src2,
  output logic [7:0]                      stall_count
);

  localparam logic [INSTR_MEM_ADDR_WIDTH-1:0] PcOne = INSTR_MEM_ADDR_WIDTH'(1);

  logic [INSTR_MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]          id_instr_q, id_instr_d;
  logic [INSTR_MEM_ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic                            id_valid_q, id_valid_d;
  logic [7:0]                      stall_count_q, stall_count_d;

  // Redirect beats stall beats advance; a redirect injects a bubble into IF/ID.
  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_valid_d    = id_valid_q;
    stall_count_d = stall_count_q;
    if (branch_taken) begin
      pc_d       = branch_target;
      id_instr_d = '0;
      id_pc_d    = '0;
      id_valid_d = 1'b0;
    end else if (!pipeline_stall_n) begin
      if (stall_count_q != 8'hFF) begin
        stall_count_d = stall_count_q + 8'd1;
      end
    end else begin
      id_instr_d = instr_mem_data;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      pc_d       = pc_q + PcOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_valid_q    <= 1'b0;
      stall_count_q <= 8'h00;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_valid_q    <= id_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instr_mem_addr   = pc_q;
  assign id_instr         = id_instr_q;
  assign id_pc            = id_pc_q;
  assign id_valid         = id_valid_q;
  assign stall_count      = stall_count_q;
  assign decoding_op_src1 = id_valid_q ? id_instr_q[8:6] : 3'b000;
  assign decoding_op_src2 = id_valid_q ? id_instr_q[5:3] : 3'b000;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus random redirect/stall/advance
// traffic checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [7:0]  instr_mem_addr;
  logic [15:0] instr_mem_data;
  logic        pipeline_stall_n;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic [2:0]  decoding_op_src1;
  logic [2:0]  decoding_op_src2;
  logic [7:0]  stall_count;

  logic [15:0] mem [256];

  // Reference state: what the stage should hold after each edge.
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_idpc;
  logic        m_valid;
  int          m_stalls;

  int n_cmp;
  int n_bad;

  instruction_fetch_stage #(
    .INSTR_WIDTH          (16),
    .INSTR_MEM_ADDR_WIDTH (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_mem_addr   (instr_mem_addr),
    .instr_mem_data   (instr_mem_data),
    .pipeline_stall_n (pipeline_stall_n),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .id_valid         (id_valid),
    .decoding_op_src1 (decoding_op_src1),
    .decoding_op_src2 (decoding_op_src2),
    .stall_count      (stall_count)
  );

  assign instr_mem_data = mem[instr_mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 8'h00;
    m_instr  = 16'h0000;
    m_idpc   = 8'h00;
    m_valid  = 1'b0;
    m_stalls = 0;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] s1;
    logic [2:0] s2;
    s1 = m_valid ? m_instr[8:6] : 3'b000;
    s2 = m_valid ? m_instr[5:3] : 3'b000;
    chk({tag, ".pc"},       32'(instr_mem_addr),   32'(m_pc));
    chk({tag, ".instr"},    32'(id_instr),         32'(m_instr));
    chk({tag, ".id_pc"},    32'(id_pc),            32'(m_idpc));
    chk({tag, ".valid"},    32'(id_valid),         32'(m_valid));
    chk({tag, ".src1"},     32'(decoding_op_src1), 32'(s1));
    chk({tag, ".src2"},     32'(decoding_op_src2), 32'(s2));
    chk({tag, ".stalls"},   32'(stall_count),      32'(m_stalls > 255 ? 255 : m_stalls));
  endtask

  // Drive one cycle's request, predict the outcome, and land 1ns after the edge.
  task automatic step(input logic br, input logic [7:0] tgt, input logic sn);
    branch_taken     = br;
    branch_target    = tgt;
    pipeline_stall_n = sn;
    if (br) begin
      m_pc    = tgt;
      m_instr = 16'h0000;
      m_idpc  = 8'h00;
      m_valid = 1'b0;
    end else if (!sn) begin
      m_stalls++;
    end else begin
      m_instr = mem[m_pc];
      m_idpc  = m_pc;
      m_valid = 1'b1;
      m_pc    = 8'((int'(m_pc) + 1) % 256);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    mem[1] = 16'h2345;
    mem[2] = 16'h3456;
    mem[3] = 16'h4567;
    branch_taken     = 1'b0;
    branch_target    = 8'h00;
    pipeline_stall_n = 1'b1;
    rst_n            = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Straight-line fetch of the first four words.
    step(1'b0, 8'h00, 1'b1);
    chk("seq0", 32'(id_instr), 32'h1234);
    step(1'b0, 8'h00, 1'b1);
    chk("seq1", 32'(id_instr), 32'h2345);
    step(1'b0, 8'h00, 1'b1);
    chk("seq2", 32'(id_instr), 32'h3456);
    step(1'b0, 8'h00, 1'b1);
    chk("seq3", 32'(id_instr), 32'h4567);
    chk("seq3_idpc", 32'(id_pc), 32'h3);
    check_all("seq");

    // Stall for three edges at PC=5, then release.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    chk("stall_pc", 32'(instr_mem_addr), 32'h5);
    chk("stall_cnt", 32'(stall_count), 32'd3);
    check_all("stall");
    step(1'b0, 8'h00, 1'b1);
    chk("release_idpc", 32'(id_pc), 32'h5);

    // Redirect wins over a simultaneous stall.
    step(1'b0, 8'h00, 1'b1);
    chk("pre_branch_pc", 32'(instr_mem_addr), 32'h7);
    step(1'b1, 8'h40, 1'b0);
    chk("br_pc", 32'(instr_mem_addr), 32'h40);
    chk("br_valid", 32'(id_valid), 32'd0);
    chk("br_src", 32'({decoding_op_src1, decoding_op_src2}), 32'd0);
    chk("br_cnt", 32'(stall_count), 32'd3);
    step(1'b0, 8'h00, 1'b1);
    chk("br_next_idpc", 32'(id_pc), 32'h40);
    check_all("branch");

    // PC wraparound.
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("wrap_idpc0", 32'(id_pc), 32'hFF);
    step(1'b0, 8'h00, 1'b1);
    chk("wrap_idpc1", 32'(id_pc), 32'h00);
    chk("wrap_pc", 32'(instr_mem_addr), 32'h01);
    check_all("wrap");

    // Random mix of redirects, stalls and advances.
    for (int i = 0; i < 200; i++) begin
      logic br;
      logic sn;
      br = ($urandom_range(0, 7) == 0);
      sn = ($urandom_range(0, 3) != 0);
      step(br, 8'($urandom), sn);
      check_all("rand");
    end

    // Counter saturation.
    for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b0);
    chk("sat_cnt", 32'(stall_count), 32'hFF);
    check_all("sat");

    // Asynchronous reset between edges while stalled.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    check_all("post_rst");

    // Reset during a pending redirect leaves nothing behind.
    branch_taken  = 1'b1;
    branch_target = 8'h33;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid_br");
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1);
    chk("rst_mid_br_idpc", 32'(id_pc), 32'h00);
    check_all("rst_mid_br_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter: INSTR_WIDTH, default 16, instruction word width in bits.
REQ-002 Parameter: INSTR_MEM_ADDR_WIDTH, default 8, PC and instruction-memory address width in bits.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 instr_mem_addr  output  INSTR_MEM_ADDR_WIDTH  current PC, driven to instruction memory.
REQ-006 instr_mem_data  input  INSTR_WIDTH  instruction at instr_mem_addr, combinational read, valid in the same cycle.
REQ-007 pipeline_stall_n  input  1  from the hazard detection unit; active-low stall request.
REQ-008 branch_taken  input  1  from EX; redirect request.
REQ-009 branch_target  input  INSTR_MEM_ADDR_WIDTH  redirect address, sampled when branch_taken=1.
REQ-010 id_instr  output  INSTR_WIDTH  IF/ID register: instruction presented to decode.
REQ-011 id_pc  output  INSTR_MEM_ADDR_WIDTH  IF/ID register: address that id_instr was fetched from.
REQ-012 id_valid  output  1  IF/ID register holds a real instruction (not a bubble).
REQ-013 decoding_op_src1  output  3  id_instr[8:6] when id_valid=1, else 0.
REQ-014 decoding_op_src2  output  3  id_instr[5:3] when id_valid=1, else 0.
REQ-015 stall_count  output  8  saturating count of stall cycles since reset.

Function
REQ-016 instr_mem_addr SHALL equal the PC register at all times, with no added latency.
REQ-017 Per rising edge, exactly one action SHALL occur, chosen by priority: redirect, then stall, then advance.
REQ-018 Redirect (branch_taken=1) SHALL load PC<=branch_target, id_instr<=0 (OP_NOP), id_pc<=0, id_valid<=0, regardless of pipeline_stall_n.
REQ-019 Stall (branch_taken=0, pipeline_stall_n=0) SHALL hold PC, id_instr, id_pc and id_valid unchanged.
REQ-020 Advance (branch_taken=0, pipeline_stall_n=1) SHALL load id_instr<=instr_mem_data, id_pc<=PC, id_valid<=1, PC<=PC+1.
REQ-021 PC increment SHALL be modulo 2^INSTR_MEM_ADDR_WIDTH (8'hFF advances to 8'h00) with no error flag.
REQ-022 Fetch-to-decode latency SHALL be one cycle: an instruction read at PC=A appears on id_instr on the edge that ends the advance cycle.
REQ-023 After a redirect, the instruction at branch_target SHALL reach id_instr one advance cycle later, giving exactly one bubble.
REQ-024 decoding_op_src1 and decoding_op_src2 SHALL be combinational from the IF/ID register only, never from instr_mem_data.
REQ-025 stall_count SHALL increment on each edge where the stall action is taken, saturate at 8'hFF, and be unaffected by redirect or advance.
REQ-026 A stall lasting N consecutive cycles SHALL leave IF/ID and PC bit-identical to their values before the stall.
REQ-027 branch_target SHALL be used as-is, with no alignment or range check.

Reset
REQ-028 While rst_n=0: PC=0, id_instr=0, id_pc=0, id_valid=0 and stall_count=0, applied immediately and independent of clk.
REQ-029 On the first rising edge after rst_n deasserts, the stage SHALL perform the normal priority action; instr_mem_addr=0 is valid from the start of that cycle.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard all pending state, with no partial update on the next edge.

Verification
REQ-031 Reset, memory[0..3]=16'h1234,16'h2345,16'h3456,16'h4567, stall_n=1 for 4 edges -> id_instr sequence 1234,2345,3456,4567; id_pc 0..3; PC=4.
REQ-032 After advancing to PC=5, hold stall_n=0 for 3 edges -> PC stays 5, IF/ID unchanged, stall_count=3; release -> id_pc=5 on the next edge.
REQ-033 At PC=7, pulse branch_taken=1 with target 8'h40 and stall_n=0 in the same cycle -> PC=8'h40, id_valid=0, src1=src2=0, stall_count unchanged; next edge -> id_pc=8'h40.
REQ-034 Redirect to 8'hFF, then advance 2 edges -> id_pc=8'hFF then 8'h00; PC=8'h01.
REQ-035 Hold stall_n=0 for 300 cycles -> stall_count=8'hFF with no wrap.
REQ-036 Assert rst_n=0 asynchronously between edges during a stall -> all outputs 0 before the next clk edge.
